// File: rtl/a2g_ctrl_serializer.sv
// ---------------------------------------------------------------------------
// a2g_ctrl_serializer
//
// Purpose:
//   Watches the 32-bit software control word. Each time bit 31 toggles, in
//   either direction, the block captures the payload ctrl_in_val[DATA_BITS-1:0]
//   and shifts it MSB-first over a 3-wire bus (spi_clk / spi_data / spi_le)
//   to the a2g gain/attenuator control chain. One further command can wait in
//   a pending slot while a transfer is running. A toggle that arrives while
//   the slot is already full is dropped and sets a sticky overrun flag.
//
// Ports:
//   user_clk     in   1          block clock
//   user_rst     in   1          asynchronous active-high reset
//   ctrl_in_val  in   32         bit31 = launch toggle, [DATA_BITS-1:0] = payload
//   spi_clk      out  1          serial clock, idles low
//   spi_data     out  1          serial data, changes only while spi_clk is low
//   spi_le       out  1          latch-enable pulse that ends each command
//   busy         out  1          high from transfer start through the GAP cycle
//   cmd_count    out  16         completed commands (wraps)
//   overrun      out  1          sticky: a toggle was dropped because pending was full
//   spi_sdo      in   1          (A2G_CTRL_READBACK_EN only) serial return data
//   readback     out  DATA_BITS  (A2G_CTRL_READBACK_EN only) last captured word
//
// Build option:
//   A2G_CTRL_READBACK_EN - when defined, adds spi_sdo/readback. spi_sdo is
//   sampled on the last user_clk cycle of each SHIFT_HI phase.
// ---------------------------------------------------------------------------
module a2g_ctrl_serializer #(
    parameter int DATA_BITS = 24,
    parameter int CLK_DIV   = 4,
    parameter int LE_CYCLES = 2
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic [31:0]          ctrl_in_val,
    output logic                 spi_clk,
    output logic                 spi_data,
    output logic                 spi_le,
    output logic                 busy,
    output logic [15:0]          cmd_count,
`ifdef A2G_CTRL_READBACK_EN
    input  logic                 spi_sdo,
    output logic [DATA_BITS-1:0] readback,
`endif
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_GAP
    } state_t;

    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LE_LAST  = CNT_W'(LE_CYCLES - 1);
    localparam logic [4:0]       BIT_LAST = 5'(DATA_BITS - 1);

    state_t               r_state, w_state_next;
    logic                 r_prev_bit31;
    logic                 r_primed;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic [4:0]           r_bit_cnt, w_bit_cnt_next;
    logic [CNT_W-1:0]     r_cyc_cnt, w_cyc_cnt_next;
    logic                 r_pend_valid, w_pend_valid_next;
    logic [DATA_BITS-1:0] r_pend_data, w_pend_data_next;
    logic                 r_spi_clk, w_spi_clk_next;
    logic                 r_spi_data, w_spi_data_next;
    logic                 r_spi_le, w_spi_le_next;
    logic                 r_busy, w_busy_next;
    logic [15:0]          r_cmd_count, w_cmd_count_next;
    logic                 r_overrun, w_overrun_next;

    logic                 w_trig;
    logic [DATA_BITS-1:0] w_payload;
    logic [DATA_BITS-1:0] w_shifted;
    logic [DATA_BITS-1:0] w_load_word;
    logic                 w_load;
    logic                 w_div_done;
    logic                 w_unused_ctrl;

    // Bits between the payload and the toggle bit are never used.
    assign w_unused_ctrl = ^(ctrl_in_val >> DATA_BITS);

    // The first cycle after reset only learns the current level of bit 31, so
    // a word that was already set before reset does not launch a command.
    assign w_trig      = r_primed & (ctrl_in_val[31] ^ r_prev_bit31);
    assign w_payload   = ctrl_in_val[DATA_BITS-1:0];
    assign w_shifted   = r_shift << 1;
    assign w_div_done  = (r_cyc_cnt == DIV_LAST);
    assign w_load_word = r_pend_valid ? r_pend_data : w_payload;

    always_comb begin
        w_state_next      = r_state;
        w_shift_next      = r_shift;
        w_bit_cnt_next    = r_bit_cnt;
        w_cyc_cnt_next    = r_cyc_cnt;
        w_pend_valid_next = r_pend_valid;
        w_pend_data_next  = r_pend_data;
        w_spi_clk_next    = r_spi_clk;
        w_spi_data_next   = r_spi_data;
        w_spi_le_next     = r_spi_le;
        w_busy_next       = r_busy;
        w_cmd_count_next  = r_cmd_count;
        w_overrun_next    = r_overrun;
        w_load            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_pend_valid || w_trig) begin
                    w_load = 1'b1;
                end
            end
            S_SHIFT_LO: begin
                if (w_div_done) begin
                    w_state_next   = S_SHIFT_HI;
                    w_spi_clk_next = 1'b1;
                    w_cyc_cnt_next = '0;
                end else begin
                    w_cyc_cnt_next = r_cyc_cnt + CNT_W'(1);
                end
            end
            S_SHIFT_HI: begin
                if (w_div_done) begin
                    w_spi_clk_next = 1'b0;
                    w_cyc_cnt_next = '0;
                    if (r_bit_cnt == 5'd0) begin
                        w_state_next    = S_LATCH;
                        w_spi_le_next   = 1'b1;
                        w_spi_data_next = 1'b0;
                    end else begin
                        // The next bit goes out on the same edge that drops
                        // spi_clk, so the data only moves while the clock is low.
                        w_state_next    = S_SHIFT_LO;
                        w_shift_next    = w_shifted;
                        w_spi_data_next = w_shifted[DATA_BITS-1];
                        w_bit_cnt_next  = r_bit_cnt - 5'd1;
                    end
                end else begin
                    w_cyc_cnt_next = r_cyc_cnt + CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (r_cyc_cnt == LE_LAST) begin
                    w_state_next   = S_GAP;
                    w_spi_le_next  = 1'b0;
                    w_cyc_cnt_next = '0;
                end else begin
                    w_cyc_cnt_next = r_cyc_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                w_cmd_count_next = r_cmd_count + 16'd1;
                if (r_pend_valid) begin
                    // Start the queued command straight away so busy never
                    // drops between the two transfers.
                    w_load = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_next    = S_SHIFT_LO;
            w_shift_next    = w_load_word;
            w_spi_data_next = w_load_word[DATA_BITS-1];
            w_bit_cnt_next  = BIT_LAST;
            w_cyc_cnt_next  = '0;
            w_busy_next     = 1'b1;
            w_spi_clk_next  = 1'b0;
            w_spi_le_next   = 1'b0;
            if (r_pend_valid) begin
                w_pend_valid_next = 1'b0;
            end
        end

        if (w_trig) begin
            if ((r_state == S_IDLE) && !r_pend_valid) begin
                // An idle launch is loaded directly by w_load above.
            end else if (!r_pend_valid || w_load) begin
                // The slot is empty, or is emptied this cycle by w_load.
                // Either way the new word takes the slot.
                w_pend_data_next  = w_payload;
                w_pend_valid_next = 1'b1;
            end else begin
                w_overrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state      <= S_IDLE;
            r_prev_bit31 <= 1'b0;
            r_primed     <= 1'b0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_cyc_cnt    <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_spi_clk    <= 1'b0;
            r_spi_data   <= 1'b0;
            r_spi_le     <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_count  <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_prev_bit31 <= ctrl_in_val[31];
            r_primed     <= 1'b1;
            r_shift      <= w_shift_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_cyc_cnt    <= w_cyc_cnt_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_data  <= w_pend_data_next;
            r_spi_clk    <= w_spi_clk_next;
            r_spi_data   <= w_spi_data_next;
            r_spi_le     <= w_spi_le_next;
            r_busy       <= w_busy_next;
            r_cmd_count  <= w_cmd_count_next;
            r_overrun    <= w_overrun_next;
        end
    end

`ifdef A2G_CTRL_READBACK_EN
    logic [DATA_BITS-1:0] r_rx;
    logic [DATA_BITS-1:0] r_readback;

    // spi_sdo is sampled at the end of each high phase, just before spi_clk
    // falls. The word is published when LATCH ends, so it is visible during GAP.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_rx       <= '0;
            r_readback <= '0;
        end else begin
            if ((r_state == S_SHIFT_HI) && w_div_done) begin
                r_rx <= (r_rx << 1) | DATA_BITS'(spi_sdo);
            end
            if ((r_state == S_LATCH) && (r_cyc_cnt == LE_LAST)) begin
                r_readback <= r_rx;
            end
        end
    end

    assign readback = r_readback;
`endif

    assign spi_clk   = r_spi_clk;
    assign spi_data  = r_spi_data;
    assign spi_le    = r_spi_le;
    assign busy      = r_busy;
    assign cmd_count = r_cmd_count;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_a2g_ctrl_serializer.sv
// ---------------------------------------------------------------------------
// tb_a2g_ctrl_serializer
//
// Directed test of a2g_ctrl_serializer at its default parameters. A table of
// single commands runs first, followed by hand-written sequences for the
// pending slot, overrun, reset in mid-shift and (when A2G_CTRL_READBACK_EN is
// defined) readback. A passive monitor rebuilds the serial frames from the
// bus and measures the spi_le width and the busy width.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_a2g_ctrl_serializer;

    localparam int DB = 24;

    logic        user_clk = 1'b0;
    logic        user_rst = 1'b1;
    logic [31:0] ctrl_in_val = 32'h0;
    wire         spi_clk;
    wire         spi_data;
    wire         spi_le;
    wire         busy;
    wire  [15:0] cmd_count;
    wire         overrun;
`ifdef A2G_CTRL_READBACK_EN
    wire         spi_sdo;
    wire [DB-1:0] readback;
    assign spi_sdo = spi_data;
`endif

    always #5 user_clk = ~user_clk;

    a2g_ctrl_serializer #(
        .DATA_BITS (24),
        .CLK_DIV   (4),
        .LE_CYCLES (2)
    ) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .ctrl_in_val (ctrl_in_val),
        .spi_clk     (spi_clk),
        .spi_data    (spi_data),
        .spi_le      (spi_le),
        .busy        (busy),
        .cmd_count   (cmd_count),
`ifdef A2G_CTRL_READBACK_EN
        .spi_sdo     (spi_sdo),
        .readback    (readback),
`endif
        .overrun     (overrun)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- bus monitor (samples on the falling edge) ------------
    logic [DB-1:0] rx = '0;
    int            nbits = 0;
    logic [DB-1:0] frames[$];
    int            fbits[$];
    int            le_run = 0, last_le = 0;
    int            busy_run = 0, last_busy = 0;
    int            le_pulses = 0, busy_rises = 0, data_viol = 0;
    logic          prev_clk = 0, prev_le = 0, prev_busy = 0, prev_data = 0;
    logic          gap_seen = 0;
    logic [DB-1:0] gap_rb = '0;

    always @(negedge user_clk) begin
        if (user_rst) begin
            rx = '0; nbits = 0; le_run = 0; busy_run = 0;
            prev_clk = 0; prev_le = 0; prev_busy = 0; prev_data = 0;
        end else begin
            if (spi_clk && !prev_clk) begin
                rx = {rx[DB-2:0], spi_data};
                nbits++;
            end
            if (spi_clk && (spi_data != prev_data)) data_viol++;
            if (spi_le && !prev_le) begin
                frames.push_back(rx);
                fbits.push_back(nbits);
                rx = '0; nbits = 0; le_pulses++;
            end
            if (spi_le) le_run++;
            else if (prev_le) begin
                last_le = le_run; le_run = 0;
`ifdef A2G_CTRL_READBACK_EN
                if (busy) begin gap_seen = 1; gap_rb = readback; end
`endif
            end
            if (busy && !prev_busy) busy_rises++;
            if (busy) busy_run++;
            else if (prev_busy) begin last_busy = busy_run; busy_run = 0; end
            prev_clk = spi_clk; prev_le = spi_le; prev_busy = busy; prev_data = spi_data;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic tick();
        @(negedge user_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!busy) begin ok = 1; break; end
        end
    endtask

    task automatic check_frame(input string name, input logic [DB-1:0] exp);
        logic [DB-1:0] f;
        int            nb;
        if (frames.size() == 0) begin
            check({name, "_present"}, 32'd0, 32'd1);
        end else begin
            f  = frames.pop_front();
            nb = fbits.pop_front();
            check(name, 32'(f), 32'(exp));
            check({name, "_bits"}, nb, DB);
            $display("frame %s: payload=0x%06h bits=%0d", name, f, nb);
        end
    endtask

    // One isolated command from idle: launch, latency, frame, timing, status.
    task automatic run_cmd(input logic [31:0] word, input logic [DB-1:0] exp_pl,
                           input logic [15:0] exp_cnt, input logic exp_ovr);
        bit ok;
        ctrl_in_val = word;
        tick();
        check("latency_busy", 32'(busy), 32'd1);
        check("first_bit", 32'(spi_data), 32'(exp_pl[DB-1]));
        wait_idle(1000, ok);
        check("busy_timeout", 32'(ok), 32'd1);
        check_frame("payload", exp_pl);
        check("le_len", last_le, 2);
        check("busy_len", last_busy, 195);
        check("cmd_count", 32'(cmd_count), 32'(exp_cnt));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("data_stable", data_viol, 0);
        $display("cmd word=0x%08h count=%0d busy_len=%0d le_len=%0d", word, cmd_count, last_busy, last_le);
    endtask

    typedef struct {
        logic [31:0]   word;
        logic [DB-1:0] pl;
        logic [15:0]   cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n0, n1;

        vecs[0] = '{32'h80ABCDEF, 24'hABCDEF, 16'd1};
        vecs[1] = '{32'h00A5A5A5, 24'hA5A5A5, 16'd2};
        vecs[2] = '{32'h80000001, 24'h000001, 16'd3};
        vecs[3] = '{32'h00000002, 24'h000002, 16'd4};
        vecs[4] = '{32'hFF123456, 24'h123456, 16'd5};

        // ---- reset state ----
        user_rst = 1'b1;
        repeat (3) tick();
        check("rst_spi_clk", 32'(spi_clk), 32'd0);
        check("rst_spi_data", 32'(spi_data), 32'd0);
        check("rst_spi_le", 32'(spi_le), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_count", 32'(cmd_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        user_rst = 1'b0;
        repeat (4) tick();

        // ---- table of single commands (alternating toggle directions) ----
        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].word, vecs[i].pl, vecs[i].cnt, 1'b0);
            repeat (5) tick();
        end

        // ---- pending queue: second toggle during the first SHIFT_HI ----
        n0 = busy_rises;
        ctrl_in_val = 32'h00111111;
        tick();
        check("pend_busy", 32'(busy), 32'd1);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (spi_clk) begin ok = 1; break; end
            tick();
        end
        check("pend_reach_hi", 32'(ok), 32'd1);
        ctrl_in_val = 32'h80222222;
        wait_idle(2000, ok);
        check("pend_timeout", 32'(ok), 32'd1);
        check_frame("pend_first", 24'h111111);
        check_frame("pend_second", 24'h222222);
        check("pend_busy_len", last_busy, 390);
        check("pend_busy_rises", busy_rises - n0, 1);
        check("pend_count", 32'(cmd_count), 32'd7);
        check("pend_overrun", 32'(overrun), 32'd0);
        repeat (5) tick();

        // ---- overrun: three toggles within the first transfer ----
        ctrl_in_val = 32'h00000001;
        repeat (5) tick();
        ctrl_in_val = 32'h80000002;
        repeat (5) tick();
        ctrl_in_val = 32'h00000003;
        tick();
        check("ovr_set", 32'(overrun), 32'd1);
        wait_idle(2000, ok);
        check("ovr_timeout", 32'(ok), 32'd1);
        check_frame("ovr_first", 24'h000001);
        check_frame("ovr_second", 24'h000002);
        check("ovr_no_third", frames.size(), 0);
        check("ovr_count", 32'(cmd_count), 32'd9);
        repeat (20) tick();
        check("ovr_sticky", 32'(overrun), 32'd1);
        check("ovr_idle", 32'(busy), 32'd0);

        // ---- reset in mid-shift ----
        ctrl_in_val = 32'h80000777;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (nbits >= 10) begin ok = 1; break; end
        end
        check("rst_reach_bit10", 32'(ok), 32'd1);
        #2;
        user_rst = 1'b1;
        #1;
        check("mrst_spi_clk", 32'(spi_clk), 32'd0);
        check("mrst_spi_data", 32'(spi_data), 32'd0);
        check("mrst_spi_le", 32'(spi_le), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_cmd_count", 32'(cmd_count), 32'd0);
        check("mrst_overrun", 32'(overrun), 32'd0);
        repeat (3) tick();
        n0 = busy_rises;
        n1 = le_pulses;
        user_rst = 1'b0;
        repeat (300) tick();
        check("mrst_no_busy", busy_rises - n0, 0);
        check("mrst_no_le", le_pulses - n1, 0);
        check("mrst_no_frame", frames.size(), 0);
        check("mrst_count", 32'(cmd_count), 32'd0);
        $display("reset mid-shift: busy_rises=%0d le_pulses=%0d count=%0d", busy_rises - n0, le_pulses - n1, cmd_count);

`ifdef A2G_CTRL_READBACK_EN
        // ---- readback: spi_sdo looped back from spi_data ----
        check("rb_reset", 32'(readback), 32'd0);
        gap_seen = 0;
        run_cmd(32'h005A5A5A, 24'h5A5A5A, 16'd1, 1'b0);
        check("rb_gap_seen", 32'(gap_seen), 32'd1);
        check("rb_gap_value", 32'(gap_rb), 32'h5A5A5A);
        $display("readback in GAP: 0x%06h", gap_rb);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
